sha1_w_sched: RTL

SHA1_W_SCHED -- requirements
Module: sha1_w_sched

---
 rtl/sha1_w_sched.sv | 101 ++++++++++
 1 files changed

// File: rtl/sha1_w_sched.sv
// SHA-1 message schedule: 16-word sliding window producing W0..W(WORDS-1) one word per adv.
// Optional macro SHA1_W_BSWAP_EN byte-reverses each captured word (little-endian block bytes).
module sha1_w_sched #(
  parameter int WORDS = 80
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [511:0] block,
  input  logic         adv,
  input  logic         clr,
  output logic [31:0]  w_t,
  output logic [6:0]   t_idx,
  output logic         w_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;

  localparam logic [6:0] LAST = 7'(WORDS - 1);

  state_t            state, state_nxt;
  logic [15:0][31:0] win, win_nxt;
  logic [15:0][31:0] cap;
  logic [6:0]        t_nxt;
  logic              done_nxt;
  logic [31:0]       mix;

  // Word 0 sits in the top 32 bits of the block.
  for (genvar i = 0; i < 16; i++) begin : g_cap
    logic [31:0] raw;
    assign raw = block[511-32*i -: 32];
`ifdef SHA1_W_BSWAP_EN
    assign cap[i] = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
`else
    assign cap[i] = raw;
`endif
  end

  assign mix = win[13] ^ win[8] ^ win[2] ^ win[0];

  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    t_nxt     = t_idx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          win_nxt   = cap;
          t_nxt     = 7'd0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          if (t_idx >= LAST) begin
            state_nxt = IDLE;
            t_nxt     = 7'd0;
            done_nxt  = 1'b1;
          end else begin
            for (int i = 0; i < 15; i++) win_nxt[i] = win[i+1];
            win_nxt[15] = {mix[30:0], mix[31]};
            t_nxt       = t_idx + 7'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = 7'd0;
      end
    endcase
    // Abort wins over everything; window contents are left as-is.
    if (clr) begin
      state_nxt = IDLE;
      t_nxt     = 7'd0;
      done_nxt  = 1'b0;
      win_nxt   = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      win   <= '0;
      t_idx <= 7'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
      t_idx <= t_nxt;
      done  <= done_nxt;
    end
  end

  assign w_t     = win[0];
  assign w_valid = (state == RUN);
  assign busy    = (state == RUN);

endmodule
